// File: rtl/mod_arith_pkg.sv
// Shared defaults and helpers for the modular-arithmetic request arbiter.
// Also holds the scalar reference for R = (A - B) mod N.
package mod_arith_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_NREQ  = 4;

   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   function automatic logic [DEF_WIDTH-1:0] mod_sub_ref(
      input logic [DEF_WIDTH-1:0] a,
      input logic [DEF_WIDTH-1:0] b,
      input logic [DEF_WIDTH-1:0] n
   );
      if (a < b) begin
         return a - b + n;
      end else begin
         return a - b;
      end
   endfunction

endpackage

// File: rtl/mod_sub_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
   import mod_arith_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_valid
);

   logic [IDW-1:0] pos_s;
   logic           found_s;

   // scan from ptr upward and take the first active request
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      pos_s     = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos_s = IDW'((32'(ptr) + 32'(k)) % 32'(NREQ));
         if (!found_s && req[pos_s]) begin
            grant[pos_s] = 1'b1;
            grant_idx    = pos_s;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      grant_valid = found_s;
   end

endmodule

// File: rtl/mod_sub_module.sv
// Combinational modular subtractor: R = A - B, corrected by +N on borrow.
module mod_sub_module #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] r
);

   logic             borrow_s;
   logic [WIDTH-1:0] diff_s;

   // subtract with borrow out, then fold the modulus back in on underflow
   always_comb begin
      {borrow_s, diff_s} = {1'b0, a} - {1'b0, b};
      if (borrow_s) begin
         r = diff_s + n;
      end else begin
         r = diff_s;
      end
   end

endmodule

// File: rtl/mod_sub_arbiter.sv
// Shares one mod_sub_module among NREQ requesters: round-robin grant,
// operand stage S1, result stage S2, one result per cycle.
module mod_sub_arbiter
   import mod_arith_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NREQ  = DEF_NREQ,
   localparam int IDW   = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_n,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_r,
   output logic [IDW-1:0]        resp_id,
   output logic                  idle
);

   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_a_r, s1_b_r, s1_n_r;
   logic [IDW-1:0]   s1_id_r;
   logic             s2_valid_r;
   logic [WIDTH-1:0] s2_r_r;
   logic [IDW-1:0]   s2_id_r;
   logic [IDW-1:0]   rr_ptr_r;

   logic [NREQ-1:0]  grant_s;
   logic [IDW-1:0]   grant_idx_s;
   logic             grant_valid_s;
   logic             s2_adv_s;
   logic             s1_load_ok_s;
   logic             hs_s;
   logic [WIDTH-1:0] mod_r_s;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req         (req_valid),
      .ptr         (rr_ptr_r),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   mod_sub_module #(.WIDTH(WIDTH)) u_mod_sub (
      .a (s1_a_r),
      .b (s1_b_r),
      .n (s1_n_r),
      .r (mod_r_s)
   );

   // pipeline advance conditions and the gated per-requester accept
   always_comb begin
      s2_adv_s     = s1_valid_r & (~s2_valid_r | resp_ready);
      s1_load_ok_s = ~s1_valid_r | s2_adv_s;
      if (grant_valid_s && s1_load_ok_s && rst_n) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
      hs_s = |(req_valid & req_ready);
   end

   // operand stage: capture the winner's operands on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= '0;
         s1_b_r     <= '0;
         s1_n_r     <= '0;
         s1_id_r    <= '0;
      end else if (hs_s) begin
         s1_valid_r <= 1'b1;
         s1_a_r     <= req_a[grant_idx_s*WIDTH +: WIDTH];
         s1_b_r     <= req_b[grant_idx_s*WIDTH +: WIDTH];
         s1_n_r     <= req_n[grant_idx_s*WIDTH +: WIDTH];
         s1_id_r    <= grant_idx_s;
      end else if (s2_adv_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // result stage: held until the consumer takes it, reloadable on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_r_r     <= '0;
         s2_id_r    <= '0;
      end else if (s2_adv_s) begin
         s2_valid_r <= 1'b1;
         s2_r_r     <= mod_r_s;
         s2_id_r    <= s1_id_r;
      end else if (resp_ready) begin
         s2_valid_r <= 1'b0;
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

   // round-robin pointer moves just past the requester that was served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else if (hs_s) begin
         if (grant_idx_s == IDW'(NREQ - 1)) begin
            rr_ptr_r <= '0;
         end else begin
            rr_ptr_r <= grant_idx_s + IDW'(1);
         end
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign resp_valid = s2_valid_r;
   assign resp_r     = s2_r_r;
   assign resp_id    = s2_id_r;
   assign idle       = ~s1_valid_r & ~s2_valid_r;

endmodule
